// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
//
// Multicycle main control unit. Decodes the 6-bit opcode held in the
// instruction register and walks each instruction through the
// fetch / decode / execute / memory / writeback sequence, driving every
// datapath enable and mux select plus the 2-bit ulaOp code consumed by
// the ALU control decoder. Memory accesses use a level-held request that
// completes in the cycle mem_ready is high.
//
// Optional feature: define ILLEGAL_TRAP_EN to send unknown opcodes to a
// sticky TRAP state (illegal=1, halted=1). Without it, unknown opcodes
// behave as a NOP and illegal is tied low.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset (forces INIT)
//   opcode[5:0]    in   IR[31:26], stable from DECODE until back in FETCH
//   mem_ready      in   memory completes the current access this cycle
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load qualified by the ALU zero flag
//   branch_ne      out  1 = qualify with !zero (BNE), 0 = with zero
//   iord           out  memory address: 0 = PC, 1 = ALU out
//   mem_read       out  memory read request
//   mem_write      out  memory write request
//   ir_write       out  instruction register load
//   reg_write      out  register file write enable
//   reg_dst        out  destination: 1 = rd, 0 = rt
//   mem_to_reg     out  write data: 1 = MDR, 0 = ALU out
//   alu_src_a      out  ALU A: 0 = PC, 1 = reg A
//   alu_src_b[1:0] out  ALU B: 00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   pc_source[1:0] out  00 ALU result, 01 ALU out reg, 10 jump target
//   ulaOp[1:0]     out  00 funct, 10 add, 01 sub, 11 immediate
//   halted         out  core stopped
//   illegal        out  illegal-opcode trap
// ---------------------------------------------------------------------------
module main_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b010000,
  parameter logic [5:0] OP_SW    = 6'b010001,
  parameter logic [5:0] OP_BEQ   = 6'b010010,
  parameter logic [5:0] OP_BNE   = 6'b010011,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_HALT  = 6'b111111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] ulaOp,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
`ifdef ILLEGAL_TRAP_EN
    ,
    S_TRAP   = 4'd14
`endif
  } state_t;

  state_t     state_q, state_d;

  // Output flops are loaded from a decode of the next state, so each one
  // is valid for exactly the cycle its state is current.
  logic       pc_write_q,      pc_write_d;
  logic       pc_write_cond_q, pc_write_cond_d;
  logic       branch_ne_q,     branch_ne_d;
  logic       iord_q,          iord_d;
  logic       mem_read_q,      mem_read_d;
  logic       mem_write_q,     mem_write_d;
  logic       reg_write_q,     reg_write_d;
  logic       reg_dst_q,       reg_dst_d;
  logic       mem_to_reg_q,    mem_to_reg_d;
  logic       alu_src_a_q,     alu_src_a_d;
  logic [1:0] alu_src_b_q,     alu_src_b_d;
  logic [1:0] pc_source_q,     pc_source_d;
  logic [1:0] ula_op_q,        ula_op_d;
  logic       halted_q,        halted_d;
  logic       fetch_q,         fetch_d;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_q,       illegal_d;
`endif

  logic       is_imm_alu;

  // Immediate ALU opcodes occupy 100000..100101.
  assign is_imm_alu = (opcode[5:3] == 3'b100) && (opcode[2:0] <= 3'd5);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE)                          state_d = S_EXEC_R;
        else if (is_imm_alu)                             state_d = S_EXEC_I;
        else if ((opcode == OP_LW) || (opcode == OP_SW))   state_d = S_ADDR;
        else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) state_d = S_BRANCH;
        else if (opcode == OP_J)                         state_d = S_JUMP;
        else if (opcode == OP_HALT)                      state_d = S_HALT;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_EXEC_I: state_d = S_WB_I;
      S_WB_I:   state_d = S_FETCH;
      // Only LW/SW reach ADDR, so anything that is not LW is a store.
      S_ADDR:   state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_INIT;
    endcase
  end

  // Output decode of the state being entered
  always_comb begin
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    branch_ne_d     = 1'b0;
    iord_d          = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    reg_write_d     = 1'b0;
    reg_dst_d       = 1'b0;
    mem_to_reg_d    = 1'b0;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = 2'b00;
    pc_source_d     = 2'b00;
    ula_op_d        = 2'b00;
    halted_d        = 1'b0;
    fetch_d         = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d       = 1'b0;
`endif
    case (state_d)
      S_FETCH: begin
        // PC increment and IR load happen only when memory delivers,
        // so those two are gated combinationally below.
        fetch_d     = 1'b1;
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
        ula_op_d    = 2'b10;
      end
      S_DECODE: begin
        alu_src_b_d = 2'b11;
        ula_op_d    = 2'b10;
      end
      S_EXEC_R: begin
        alu_src_a_d = 1'b1;
      end
      S_WB_R: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        ula_op_d    = 2'b11;
      end
      S_WB_I: begin
        reg_write_d = 1'b1;
      end
      S_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        ula_op_d    = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d     = 1'b1;
        ula_op_d        = 2'b01;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 2'b01;
        branch_ne_d     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        halted_d  = 1'b1;
        illegal_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State and registered outputs; async reset lands everything in INIT
  // with all outputs low, dropping any in-flight memory request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_INIT;
      pc_write_q      <= 1'b0;
      pc_write_cond_q <= 1'b0;
      branch_ne_q     <= 1'b0;
      iord_q          <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      reg_write_q     <= 1'b0;
      reg_dst_q       <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      alu_src_a_q     <= 1'b0;
      alu_src_b_q     <= 2'b00;
      pc_source_q     <= 2'b00;
      ula_op_q        <= 2'b00;
      halted_q        <= 1'b0;
      fetch_q         <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      pc_write_q      <= pc_write_d;
      pc_write_cond_q <= pc_write_cond_d;
      branch_ne_q     <= branch_ne_d;
      iord_q          <= iord_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      reg_write_q     <= reg_write_d;
      reg_dst_q       <= reg_dst_d;
      mem_to_reg_q    <= mem_to_reg_d;
      alu_src_a_q     <= alu_src_a_d;
      alu_src_b_q     <= alu_src_b_d;
      pc_source_q     <= pc_source_d;
      ula_op_q        <= ula_op_d;
      halted_q        <= halted_d;
      fetch_q         <= fetch_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q       <= illegal_d;
`endif
    end
  end

  // pc_write is the JUMP load or the FETCH increment completing this cycle.
  assign pc_write      = pc_write_q | (fetch_q & mem_ready);
  assign ir_write      = fetch_q & mem_ready;
  assign pc_write_cond = pc_write_cond_q;
  assign branch_ne     = branch_ne_q;
  assign iord          = iord_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign reg_write     = reg_write_q;
  assign reg_dst       = reg_dst_q;
  assign mem_to_reg    = mem_to_reg_q;
  assign alu_src_a     = alu_src_a_q;
  assign alu_src_b     = alu_src_b_q;
  assign pc_source     = pc_source_q;
  assign ulaOp         = ula_op_q;
  assign halted        = halted_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal       = illegal_q;
`else
  assign illegal       = 1'b0;
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_control_fsm
//
// Directed testbench for main_control_fsm. Each scenario resets the DUT,
// applies an opcode and a per-cycle mem_ready pattern, and compares the
// full packed output vector against hand-written per-state expectations.
// ---------------------------------------------------------------------------
module tb_main_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b010000;
  localparam logic [5:0] OP_SW    = 6'b010001;
  localparam logic [5:0] OP_BEQ   = 6'b010010;
  localparam logic [5:0] OP_BNE   = 6'b010011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_SUBI  = 6'b100011;
  localparam logic [5:0] OP_BAD   = 6'b001100;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_source, ulaOp;
  logic       halted, illegal;

  int checks;
  int errors;

  main_control_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .ulaOp         (ulaOp),
    .halted        (halted),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pw,pwc,bne,iord,mr,mw,irw,rw,rd,m2r,asa,asb[1:0],pcs[1:0],op[1:0],h,il}
  logic [18:0] outs;
  assign outs = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                 ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                 alu_src_b, pc_source, ulaOp, halted, illegal};

  function automatic logic [18:0] ov(
    input logic pw, pwc, bne, io, mr, mw, irw, rw, rd, m2r, asa,
    input logic [1:0] asb, pcs, op,
    input logic h, il
  );
    return {pw, pwc, bne, io, mr, mw, irw, rw, rd, m2r, asa, asb, pcs, op, h, il};
  endfunction

  logic [18:0] E_INIT, E_FETCH_R, E_FETCH_W, E_DECODE, E_EXEC_R, E_WB_R;
  logic [18:0] E_EXEC_I, E_WB_I, E_ADDR, E_MEM_RD, E_WB_MEM, E_MEM_WR;
  logic [18:0] E_BNE, E_BEQ, E_JUMP, E_HALT, E_TRAP;

  initial begin
    //              pw pwc bne io mr mw irw rw rd m2r asa asb    pcs    op     h  il
    E_INIT    = ov(0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  0,  2'b00, 2'b00, 2'b00, 0, 0);
    E_FETCH_R = ov(1, 0,  0,  0, 1, 0, 1,  0, 0, 0,  0,  2'b01, 2'b00, 2'b10, 0, 0);
    E_FETCH_W = ov(0, 0,  0,  0, 1, 0, 0,  0, 0, 0,  0,  2'b01, 2'b00, 2'b10, 0, 0);
    E_DECODE  = ov(0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  0,  2'b11, 2'b00, 2'b10, 0, 0);
    E_EXEC_R  = ov(0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  1,  2'b00, 2'b00, 2'b00, 0, 0);
    E_WB_R    = ov(0, 0,  0,  0, 0, 0, 0,  1, 1, 0,  0,  2'b00, 2'b00, 2'b00, 0, 0);
    E_EXEC_I  = ov(0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  1,  2'b10, 2'b00, 2'b11, 0, 0);
    E_WB_I    = ov(0, 0,  0,  0, 0, 0, 0,  1, 0, 0,  0,  2'b00, 2'b00, 2'b00, 0, 0);
    E_ADDR    = ov(0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  1,  2'b10, 2'b00, 2'b10, 0, 0);
    E_MEM_RD  = ov(0, 0,  0,  1, 1, 0, 0,  0, 0, 0,  0,  2'b00, 2'b00, 2'b00, 0, 0);
    E_WB_MEM  = ov(0, 0,  0,  0, 0, 0, 0,  1, 0, 1,  0,  2'b00, 2'b00, 2'b00, 0, 0);
    E_MEM_WR  = ov(0, 0,  0,  1, 0, 1, 0,  0, 0, 0,  0,  2'b00, 2'b00, 2'b00, 0, 0);
    E_BNE     = ov(0, 1,  1,  0, 0, 0, 0,  0, 0, 0,  1,  2'b00, 2'b01, 2'b01, 0, 0);
    E_BEQ     = ov(0, 1,  0,  0, 0, 0, 0,  0, 0, 0,  1,  2'b00, 2'b01, 2'b01, 0, 0);
    E_JUMP    = ov(1, 0,  0,  0, 0, 0, 0,  0, 0, 0,  0,  2'b00, 2'b10, 2'b00, 0, 0);
    E_HALT    = ov(0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  0,  2'b00, 2'b00, 2'b00, 1, 0);
    E_TRAP    = ov(0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  0,  2'b00, 2'b00, 2'b00, 1, 1);
  end

  // Leaves the DUT just released from reset at a falling edge (still INIT).
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_RTYPE;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (outs !== E_INIT) begin
      $display("FAIL reset_held: got %b expected %b", outs, E_INIT);
      errors++;
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs !== E_INIT) begin
      $display("FAIL reset_release_init: got %b expected %b", outs, E_INIT);
      errors++;
    end
  endtask

  task automatic test_rtype();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_RTYPE;
    e = '{E_FETCH_R, E_DECODE, E_EXEC_R, E_WB_R, E_FETCH_R};
    m = '{1, 1, 0, 0, 1};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL rtype step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
  endtask

  task automatic test_imm();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_SUBI;
    e = '{E_FETCH_R, E_DECODE, E_EXEC_I, E_WB_I, E_FETCH_R};
    m = '{1, 1, 1, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL imm step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
  endtask

  task automatic test_load_wait();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_LW;
    e = '{E_FETCH_R, E_DECODE, E_ADDR, E_MEM_RD, E_MEM_RD, E_MEM_RD, E_WB_MEM, E_FETCH_W};
    m = '{1, 0, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL load_wait step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
  endtask

  task automatic test_store();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_SW;
    e = '{E_FETCH_R, E_DECODE, E_ADDR, E_MEM_WR, E_FETCH_R};
    m = '{1, 1, 1, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL store step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_SW;
    e = '{E_FETCH_R, E_DECODE, E_ADDR, E_MEM_WR, E_MEM_WR};
    m = '{1, 0, 0, 0, 0};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL reset_mid_store step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== E_INIT) begin
      $display("FAIL reset_mid_store_drop: got %b expected %b", outs, E_INIT);
      errors++;
    end
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== E_INIT) begin
      $display("FAIL reset_mid_store_init: got %b expected %b", outs, E_INIT);
      errors++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (outs !== E_FETCH_R) begin
      $display("FAIL reset_mid_store_fetch: got %b expected %b", outs, E_FETCH_R);
      errors++;
    end
  endtask

  task automatic test_branch_ne();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_BNE;
    e = '{E_FETCH_R, E_DECODE, E_BNE, E_FETCH_R};
    m = '{1, 1, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL branch_ne step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
  endtask

  task automatic test_branch_eq();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_BEQ;
    e = '{E_FETCH_R, E_DECODE, E_BEQ, E_FETCH_W};
    m = '{1, 0, 1, 0};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL branch_eq step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
  endtask

  task automatic test_jump_fetch_wait();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_J;
    e = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_JUMP, E_FETCH_R};
    m = '{0, 0, 1, 1, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL jump step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
  endtask

  task automatic test_halt();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_HALT;
    e = '{E_FETCH_R, E_DECODE};
    m = '{1, 1};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL halt_entry step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
    // Sticky across 20 cycles with mem_ready and opcode toggling.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = i[0];
      opcode    = i[0] ? OP_J : OP_HALT;
      #1;
      checks++;
      if (outs !== E_HALT) begin
        $display("FAIL halt_hold cycle %0d: got %b expected %b", i, outs, E_HALT);
        errors++;
      end
    end
  endtask

  task automatic test_illegal();
    logic [18:0] e[$];
    bit          m[$];
    do_reset();
    opcode = OP_BAD;
`ifdef ILLEGAL_TRAP_EN
    e = '{E_FETCH_R, E_DECODE, E_TRAP, E_TRAP, E_TRAP, E_TRAP};
`else
    e = '{E_FETCH_R, E_DECODE, E_FETCH_R, E_DECODE, E_FETCH_W, E_FETCH_R};
`endif
    m = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      mem_ready = m[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        $display("FAIL illegal step %0d: got %b expected %b", i, outs, e[i]);
        errors++;
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = OP_RTYPE;
    test_reset();
    test_rtype();
    test_imm();
    test_load_wait();
    test_store();
    test_reset_mid_store();
    test_branch_ne();
    test_branch_eq();
    test_jump_fetch_wait();
    test_halt();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multicycle main control unit for the CPU datapath.
- Decodes the 6-bit instruction opcode and sequences fetch/decode/execute/memory/writeback.
- Drives the 2-bit ulaOp code consumed by the ALU control decoder, plus all datapath enables and mux selects.
- Sits between the instruction register and the datapath; talks to unified memory through a ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type (ALU function taken from funct field).
- OP_LW, 6'b010000, load word.
- OP_SW, 6'b010001, store word.
- OP_BEQ, 6'b010010, branch if equal.
- OP_BNE, 6'b010011, branch if not equal.
- OP_J, 6'b000010, jump.
- OP_HALT, 6'b111111, halt.
- Immediate ALU opcodes are fixed, not parameters: 6'b100000..6'b100101.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by the ALU zero flag.
- branch_ne  out  1  1 = qualify with !zero (BNE); 0 = qualify with zero.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write data: 1 = MDR, 0 = ALU out.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = reg A.
- alu_src_b  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALU out register, 10 = jump target.
- ulaOp  out  2  00 = R-type/funct, 10 = add, 01 = sub, 11 = immediate (decoded from opcode).
- halted  out  1  core stopped.
- illegal  out  1  illegal-opcode trap (feature-dependent).

Behaviour:
- State register is updated on rising clk. rst_n low forces INIT asynchronously.
- In INIT every output is 0, including ulaOp = 00. INIT -> FETCH after one cycle.
- Outputs not listed for a state are 0. Outputs are decoded from state only, except pc_write/ir_write in FETCH, which are gated by mem_ready.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ulaOp=10, pc_source=00. pc_write=ir_write=mem_ready. Stay in FETCH while !mem_ready; -> DECODE when mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, ulaOp=10 (branch target computed). Next state by opcode:
  - OP_RTYPE -> EXEC_R
  - 1000xx / 10010x in range 100000..100101 -> EXEC_I
  - OP_LW / OP_SW -> ADDR
  - OP_BEQ / OP_BNE -> BRANCH
  - OP_J -> JUMP
  - OP_HALT -> HALT
  - anything else -> see Optional Feature.
- EXEC_R: alu_src_a=1, alu_src_b=00, ulaOp=00 -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ulaOp=11 -> WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, ulaOp=10. -> MEM_RD if OP_LW, MEM_WR if OP_SW.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then -> WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ulaOp=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==OP_BNE) -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- HALT: halted=1, all other outputs 0. Sticky; exits only via rst_n.
- Requests are level-held: mem_read/mem_write stay asserted until the cycle mem_ready is seen high.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Instruction latencies (zero-wait memory): R/I = 4, LW = 5, SW = 4, branch/jump = 3 cycles.
- Reset mid-access (e.g., in MEM_WR) drops mem_write the same instant rst_n falls.
- mem_read and mem_write are never asserted together.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP state. TRAP drives illegal=1 and halted=1, all else 0, and is sticky until reset.
- Undefined: an unknown opcode is a NOP (DECODE -> FETCH). The illegal output is tied to 0 and the TRAP state does not exist.

Test Plan:
- Reset, then opcode=000000 with mem_ready=1 -> INIT, FETCH, DECODE, EXEC_R (ulaOp=00), WB_R (reg_write=1, reg_dst=1), FETCH.
- opcode=100011 (sub immediate) -> EXEC_I shows ulaOp=11, alu_src_b=10; WB_I reg_dst=0.
- opcode=010000 with mem_ready low 2 cycles in MEM_RD -> mem_read and iord held 3 cycles; WB_MEM mem_to_reg=1; total 7 cycles.
- opcode=010011 -> BRANCH ulaOp=01, pc_write_cond=1, branch_ne=1, pc_source=01; opcode=000010 -> JUMP pc_write=1, pc_source=10.
- rst_n pulsed low while in MEM_WR -> mem_write=0 immediately; INIT, then FETCH after release.
- opcode=111111 -> halted=1 held 20 cycles; opcode=001100 -> illegal=1 with ILLEGAL_TRAP_EN, back to FETCH without it.
